// File: rtl/parc_dmem_resp_queue.sv
// Data-memory response queue: subword extraction at enqueue,
// circular-buffer storage and optional empty-queue pass-through.
module parc_dmem_resp_queue #(
    parameter int p_data_nbits  = 32,
    parameter int p_num_entries = 2,
    parameter int p_bypass      = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enq_val,
    output logic                             enq_rdy,
    input  logic [p_data_nbits-1:0]          enq_msg_data,
    input  logic [2:0]                       enq_msg_type,
    output logic                             deq_val,
    input  logic                             deq_rdy,
    output logic [p_data_nbits-1:0]          deq_msg,
    output logic [$clog2(p_num_entries):0]   count,
    output logic                             full,
    output logic                             empty
);

    localparam int c_aw = $clog2(p_num_entries);
    localparam int c_cw = c_aw + 1;
    localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);
    localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_max = c_cw'(p_num_entries);
    localparam logic c_byp = (p_bypass != 0);

    logic [p_data_nbits-1:0] r_mem [p_num_entries];
    logic [c_aw-1:0]         r_enq_ptr;
    logic [c_aw-1:0]         r_deq_ptr;
    logic [c_cw-1:0]         r_count;

    logic [p_data_nbits-1:0] w_ext;
    logic                    w_enq_fire;
    logic                    w_deq_fire;
    logic                    w_pass;
    logic                    w_write;
    logic                    w_pop;

    assign count   = r_count;
    assign full    = (r_count == c_cnt_max);
    assign empty   = (r_count == '0);
    assign enq_rdy = !full && !reset;

    // Subword extraction of the incoming response
    always_comb begin
        w_ext = enq_msg_data;
        case (enq_msg_type)
            3'd1: w_ext = {{(p_data_nbits-8){enq_msg_data[7]}},
                           enq_msg_data[7:0]};
            3'd2: w_ext = {{(p_data_nbits-8){1'b0}},
                           enq_msg_data[7:0]};
            3'd3: w_ext = {{(p_data_nbits-16){enq_msg_data[15]}},
                           enq_msg_data[15:0]};
            3'd4: w_ext = {{(p_data_nbits-16){1'b0}},
                           enq_msg_data[15:0]};
            default: w_ext = enq_msg_data;
        endcase
    end

    // Head selection: stored entry, or pass-through when empty
    always_comb begin
        deq_val = 1'b0;
        deq_msg = r_mem[r_deq_ptr];
        if (reset) begin
            deq_val = 1'b0;
        end else if (!empty) begin
            deq_val = 1'b1;
        end else if (c_byp) begin
            deq_val = enq_val;
            deq_msg = w_ext;
        end
    end

    // A pass-through consumes the message without touching storage
    assign w_enq_fire = enq_val && enq_rdy;
    assign w_deq_fire = deq_val && deq_rdy;
    assign w_pass     = c_byp && empty && deq_rdy;
    assign w_write    = w_enq_fire && !w_pass;
    assign w_pop      = w_deq_fire && !empty;

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enq_ptr <= '0;
            r_deq_ptr <= '0;
            r_count   <= '0;
        end else begin
            if (w_write) r_enq_ptr <= r_enq_ptr + c_ptr_one;
            if (w_pop)   r_deq_ptr <= r_deq_ptr + c_ptr_one;
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents survive reset and are simply ignored
    always_ff @(posedge clk) begin
        if (w_write) r_mem[r_enq_ptr] <= w_ext;
    end

endmodule

// File: tb/tb_parc_dmem_resp_queue.sv
// Randomized scoreboard bench for the dmem response queue.
// Two instances: default (2 deep, pass-through) and 4 deep registered.
module tb_parc_dmem_resp_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        enq_val;
    logic [31:0] enq_msg_data;
    logic [2:0]  enq_msg_type;
    logic        deq_rdy;

    logic        rdy0, dv0, full0, empty0;
    logic [31:0] dm0;
    logic [1:0]  cnt0;
    logic        rdy1, dv1, full1, empty1;
    logic [31:0] dm1;
    logic [2:0]  cnt1;

    int checks = 0;
    int passes = 0;

    logic [31:0] sb0 [$];
    logic [31:0] sb1 [$];
    int          occ [2];
    int          depth [2];
    int          byp [2];

    always #5 clk = ~clk;

    parc_dmem_resp_queue u_dut0 (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_rdy(rdy0),
        .enq_msg_data(enq_msg_data), .enq_msg_type(enq_msg_type),
        .deq_val(dv0), .deq_rdy(deq_rdy), .deq_msg(dm0),
        .count(cnt0), .full(full0), .empty(empty0)
    );

    parc_dmem_resp_queue #(
        .p_data_nbits(32), .p_num_entries(4), .p_bypass(0)
    ) u_dut1 (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_rdy(rdy1),
        .enq_msg_data(enq_msg_data), .enq_msg_type(enq_msg_type),
        .deq_val(dv1), .deq_rdy(deq_rdy), .deq_msg(dm1),
        .count(cnt1), .full(full1), .empty(empty1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                      name, act, exp, $time);
    endtask

    // Reference extraction written as integer arithmetic
    function automatic logic [31:0] ext(input logic [31:0] d,
                                        input logic [2:0] t);
        longint b;
        longint h;
        b = longint'(d % 256);
        h = longint'(d % 65536);
        case (t)
            3'd1: return 32'(b >= 128 ? b - 256 : b);
            3'd2: return 32'(b);
            3'd3: return 32'(h >= 32768 ? h - 65536 : h);
            3'd4: return 32'(h);
            default: return d;
        endcase
    endfunction

    // Output monitors: every dequeue pops the oldest accepted message
    always @(negedge clk) begin
        if (dv0 === 1'b1 && deq_rdy) begin
            if (sb0.size() == 0) begin
                checks++;
                $display("FAIL deq0_extra: got 0x%08h expected none", dm0);
            end else begin
                chk("deq0_msg", dm0, sb0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (dv1 === 1'b1 && deq_rdy) begin
            if (sb1.size() == 0) begin
                checks++;
                $display("FAIL deq1_extra: got 0x%08h expected none", dm1);
            end else begin
                chk("deq1_msg", dm1, sb1.pop_front());
            end
        end
    end

    // One cycle of stimulus plus control-signal prediction
    task automatic step(input logic rst, input logic ev,
                        input logic [31:0] d, input logic [2:0] t,
                        input logic dr);
        logic prdy [2];
        logic pdv  [2];
        logic ef   [2];
        logic df   [2];
        reset        = rst;
        enq_val      = ev;
        enq_msg_data = d;
        enq_msg_type = t;
        deq_rdy      = dr;
        for (int k = 0; k < 2; k++) begin
            prdy[k] = !rst && occ[k] < depth[k];
            pdv[k]  = !rst && (occ[k] > 0 || (byp[k] == 1 && ev));
            ef[k]   = ev && prdy[k];
            df[k]   = pdv[k] && dr;
        end
        if (ef[0]) sb0.push_back(ext(d, t));
        if (ef[1]) sb1.push_back(ext(d, t));
        @(negedge clk);
        chk("enq_rdy0", 32'(rdy0), 32'(prdy[0]));
        chk("deq_val0", 32'(dv0), 32'(pdv[0]));
        chk("count0", 32'(cnt0), 32'(occ[0]));
        chk("full0", 32'(full0), 32'(occ[0] == depth[0]));
        chk("empty0", 32'(empty0), 32'(occ[0] == 0));
        chk("enq_rdy1", 32'(rdy1), 32'(prdy[1]));
        chk("deq_val1", 32'(dv1), 32'(pdv[1]));
        chk("count1", 32'(cnt1), 32'(occ[1]));
        chk("full1", 32'(full1), 32'(occ[1] == depth[1]));
        chk("empty1", 32'(empty1), 32'(occ[1] == 0));
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) occ[k] = 0;
            else occ[k] = occ[k] + int'(ef[k]) - int'(df[k]);
        end
        if (rst) begin
            sb0.delete();
            sb1.delete();
        end
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 32'h0, 3'd0, 1);
    endtask

    initial begin
        depth = '{2, 4};
        byp   = '{1, 0};
        occ   = '{0, 0};
        reset = 1'b1;
        enq_val = 1'b0;
        enq_msg_data = '0;
        enq_msg_type = '0;
        deq_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // reset holds handshakes low even with enq_val
        step(1, 1, 32'h1234, 3'd0, 1);
        // sign-extended byte passes straight through when empty
        step(0, 1, 32'h000000F0, 3'd1, 1);
        drain(2);
        // fill and drain
        step(0, 1, 32'h11111111, 3'd0, 0);
        step(0, 1, 32'h22223344, 3'd4, 0);
        step(0, 1, 32'hDEADBEEF, 3'd0, 0);
        drain(4);
        // simultaneous traffic at occupancy one
        step(0, 1, 32'hA0A0A0A0, 3'd0, 0);
        for (int i = 0; i < 8; i++)
            step(0, 1, $urandom, 3'($urandom_range(0, 7)), 1);
        drain(5);
        // full with both sides active: only the dequeue fires
        step(0, 1, 32'h0000_0081, 3'd1, 0);
        step(0, 1, 32'h0000_8001, 3'd3, 0);
        step(0, 1, 32'h0BAD_0BAD, 3'd0, 1);
        drain(5);
        // reset discards stored entries
        step(0, 1, 32'h13579BDF, 3'd0, 0);
        step(0, 1, 32'h2468ACE0, 3'd0, 0);
        step(1, 0, 32'h0, 3'd0, 0);
        step(0, 1, 32'h0000005A, 3'd2, 1);
        drain(3);
        // registered-only instance sees one cycle of latency
        step(0, 1, 32'h00008000, 3'd3, 0);
        drain(3);
        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 39) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom,
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2) != 0);
        end
        drain(6);
        chk("sb0_left", 32'(sb0.size()), 32'd0);
        chk("sb1_left", 32'(sb1.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
